// File: rtl/clock_set_if.sv
// Handshake/bus bundle between the digital-clock front end and its
// neighbours: raw buttons and the 1 Hz tick in, counter controls and display
// information out.
interface clock_set_if;
   logic       pulse_1s;
   logic       btn_mode_n;
   logic       btn_up_n;
   logic       btn_down_n;

   logic       enable_cnt_h;
   logic       enable_cnt_mi;
   logic       enable_cnt_s;
   logic       increase_h;
   logic       decrease_h;
   logic       increase_mi;
   logic       decrease_mi;
   logic       increase_s;
   logic       decrease_s;
   logic [1:0] mode;
   logic       blink;

   // Control block side: consumes buttons and tick, produces counter controls.
   modport slave (
      input  pulse_1s, btn_mode_n, btn_up_n, btn_down_n,
      output enable_cnt_h, enable_cnt_mi, enable_cnt_s,
             increase_h, decrease_h, increase_mi, decrease_mi,
             increase_s, decrease_s, mode, blink
   );

   // Environment side: drives buttons and tick, observes counter controls.
   modport master (
      output pulse_1s, btn_mode_n, btn_up_n, btn_down_n,
      input  enable_cnt_h, enable_cnt_mi, enable_cnt_s,
             increase_h, decrease_h, increase_mi, decrease_mi,
             increase_s, decrease_s, mode, blink
   );
endinterface

// File: rtl/clock_set_ctrl.sv
// Front-end control stage of the digital clock: debounces the mode/up/down
// buttons, runs the RUN/SET mode FSM with an inactivity timeout, and produces
// the counter enables, the active-low adjust levels and the display blink.
// Every output is a flop; the flops load the values that take effect in the
// same cycle as a debounced edge, so a clean raw edge shows up on the
// outputs DEBOUNCE_CYCLES+2 clocks later.
module clock_set_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TIMEOUT_S       = 10
) (
   input  logic       clk,
   input  logic       rst,
   clock_set_if.slave bus
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      SET_H  = 2'd1,
      SET_MI = 2'd2,
      SET_S  = 2'd3
   } mode_t;

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TO_W = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S + 1) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_S - 1);

   // Button bit positions inside the packed button vectors.
   localparam int B_MODE = 0;
   localparam int B_UP   = 1;
   localparam int B_DOWN = 2;

   // ---------------------------------------------------------------------
   // Debounce
   // ---------------------------------------------------------------------
   logic [2:0]      btn_raw;
   logic [2:0]      sync1;
   logic [2:0]      sync2;
   logic [2:0]      deb;
   logic [2:0]      deb_nx;
   logic [2:0]      db_fire;
   logic [DB_W-1:0] db_cnt [3];

   assign btn_raw = {bus.btn_down_n, bus.btn_up_n, bus.btn_mode_n};

   // Two-flop synchronizer for the asynchronous raw buttons.
   // NOTE: synchronizer and debounced levels reset to 1 (released); resetting
   // them to 0 would look like a press of every button as reset is released.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         // NOTE: non-blocking assignments let sync2 take the old sync1, giving
         // a true two-stage chain; blocking here would collapse it to one flop.
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   // Decide which buttons accept their synced level this cycle.
   // NOTE: every always_comb output gets a default before any conditional
   // assignment, otherwise a path that skips it infers a latch.
   always_comb begin
      db_fire = '0;
      for (int i = 0; i < 3; i++) begin
         db_fire[i] = (sync2[i] != deb[i]) && (db_cnt[i] == DB_LAST);
      end
      deb_nx = (deb & ~db_fire) | (sync2 & db_fire);
   end

   // Stability counters and debounced levels.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb <= '1;
         for (int i = 0; i < 3; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         deb <= deb_nx;
         for (int i = 0; i < 3; i++) begin
            if ((sync2[i] == deb[i]) || db_fire[i]) begin
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Mode, timeout, masking and blink: next-state decode
   // ---------------------------------------------------------------------
   mode_t           mode_q;
   mode_t           mode_nx;
   logic [TO_W-1:0] to_cnt;
   logic [TO_W-1:0] to_cnt_nx;
   logic [1:0]      mask_q;      // [0] up, [1] down
   logic [1:0]      mask_nx;
   logic            blink_q;
   logic            blink_nx;
   logic            mode_press;
   logic            any_edge;
   logic            timeout_fire;
   logic            transition;
   logic            up_lvl;
   logic            down_lvl;

   assign mode_press = db_fire[B_MODE] & ~deb_nx[B_MODE];
   assign any_edge   = |db_fire;
   // A masked button behaves as released towards the counters.
   assign up_lvl     = deb_nx[B_UP]   | mask_nx[0];
   assign down_lvl   = deb_nx[B_DOWN] | mask_nx[1];

   // Timeout counting and mode sequencing; a mode press overrides a timeout.
   always_comb begin
      mode_nx      = mode_q;
      to_cnt_nx    = to_cnt;
      timeout_fire = 1'b0;

      if (mode_q == RUN) begin
         to_cnt_nx = '0;
      end else if (any_edge) begin
         to_cnt_nx = '0;
      end else if (bus.pulse_1s) begin
         if (to_cnt == TO_LAST) begin
            timeout_fire = 1'b1;
            to_cnt_nx    = '0;
         end else begin
            to_cnt_nx = to_cnt + 1'b1;
         end
      end

      if (mode_press) begin
         timeout_fire = 1'b0;
         to_cnt_nx    = '0;
         case (mode_q)
            RUN:     mode_nx = SET_H;
            SET_H:   mode_nx = SET_MI;
            SET_MI:  mode_nx = SET_S;
            default: mode_nx = RUN;
         endcase
      end else if (timeout_fire) begin
         mode_nx = RUN;
      end

      transition = mode_press | timeout_fire;

      // A button already held at a mode change stays masked until released.
      mask_nx = (mask_q | {2{transition}}) & ~{deb_nx[B_DOWN], deb_nx[B_UP]};

      if ((mode_nx == RUN) || transition) begin
         blink_nx = 1'b0;
      end else begin
         blink_nx = blink_q ^ bus.pulse_1s;
      end
   end

   // ---------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------
   logic       en_h_q,  en_mi_q,  en_s_q;
   logic       inc_h_q, dec_h_q;
   logic       inc_mi_q, dec_mi_q;
   logic       inc_s_q, dec_s_q;

   // Mode FSM state plus all outputs, derived from next-state values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q   <= RUN;
         to_cnt   <= '0;
         mask_q   <= '0;
         blink_q  <= 1'b0;
         en_h_q   <= 1'b1;
         en_mi_q  <= 1'b1;
         en_s_q   <= 1'b1;
         inc_h_q  <= 1'b1;
         dec_h_q  <= 1'b1;
         inc_mi_q <= 1'b1;
         dec_mi_q <= 1'b1;
         inc_s_q  <= 1'b1;
         dec_s_q  <= 1'b1;
      end else begin
         mode_q   <= mode_nx;
         to_cnt   <= to_cnt_nx;
         mask_q   <= mask_nx;
         blink_q  <= blink_nx;
         en_h_q   <= (mode_nx == RUN) || (mode_nx == SET_H);
         en_mi_q  <= (mode_nx == RUN) || (mode_nx == SET_MI);
         en_s_q   <= (mode_nx == RUN) || (mode_nx == SET_S);
         inc_h_q  <= (mode_nx == SET_H)  ? up_lvl   : 1'b1;
         dec_h_q  <= (mode_nx == SET_H)  ? down_lvl : 1'b1;
         inc_mi_q <= (mode_nx == SET_MI) ? up_lvl   : 1'b1;
         dec_mi_q <= (mode_nx == SET_MI) ? down_lvl : 1'b1;
         inc_s_q  <= (mode_nx == SET_S)  ? up_lvl   : 1'b1;
         dec_s_q  <= (mode_nx == SET_S)  ? down_lvl : 1'b1;
      end
   end

   assign bus.mode          = mode_q;
   assign bus.blink         = blink_q;
   assign bus.enable_cnt_h  = en_h_q;
   assign bus.enable_cnt_mi = en_mi_q;
   assign bus.enable_cnt_s  = en_s_q;
   assign bus.increase_h    = inc_h_q;
   assign bus.decrease_h    = dec_h_q;
   assign bus.increase_mi   = inc_mi_q;
   assign bus.decrease_mi   = dec_mi_q;
   assign bus.increase_s    = inc_s_q;
   assign bus.decrease_s    = dec_s_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with DEBOUNCE_CYCLES=4, TIMEOUT_S=3.
// A table of button steps with expected outputs covers the mode sequence,
// routing and masking; hand-written sequences cover debounce latency,
// glitch rejection, timeout and reset.
module tb_clock_set_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   clock_set_if bus ();

   clock_set_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .TIMEOUT_S       (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       m;
      logic       u;
      logic       d;
      int         cycles;
      logic [1:0] mode;
      logic [2:0] en;    // {h, mi, s}
      logic [5:0] adj;   // {inc_h, dec_h, inc_mi, dec_mi, inc_s, dec_s}
      logic       blink;
   } vec_t;

   vec_t vecs [$];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] adj_now();
      return {bus.increase_h, bus.decrease_h, bus.increase_mi,
              bus.decrease_mi, bus.increase_s, bus.decrease_s};
   endfunction

   function automatic logic [2:0] en_now();
      return {bus.enable_cnt_h, bus.enable_cnt_mi, bus.enable_cnt_s};
   endfunction

   task automatic pulse();
      bus.pulse_1s = 1'b1;
      tick(1);
      bus.pulse_1s = 1'b0;
   endtask

   task automatic press_mode();
      bus.btn_mode_n = 1'b0;
      tick(10);
      bus.btn_mode_n = 1'b1;
      tick(10);
   endtask

   task automatic add(input string n, input logic m, input logic u,
                      input logic d, input int c, input logic [1:0] mo,
                      input logic [2:0] en, input logic [5:0] adj);
      vec_t v;
      v.name = n; v.m = m; v.u = u; v.d = d; v.cycles = c;
      v.mode = mo; v.en = en; v.adj = adj; v.blink = 1'b0;
      vecs.push_back(v);
   endtask

   initial begin
      logic ok;

      // Steps start from RUN with all buttons released; no pulse_1s here.
      add("idle",         1, 1, 1,  2, 0, 3'b111, 6'b111111);
      add("glitch3",      0, 1, 1,  3, 0, 3'b111, 6'b111111);
      add("glitch_after", 1, 1, 1, 10, 0, 3'b111, 6'b111111);
      add("press_seth",   0, 1, 1, 10, 1, 3'b100, 6'b111111);
      add("rel_mode",     1, 1, 1, 10, 1, 3'b100, 6'b111111);
      add("up_h",         1, 0, 1, 10, 1, 3'b100, 6'b011111);
      add("up_h_rel",     1, 1, 1, 10, 1, 3'b100, 6'b111111);
      add("down_h",       1, 1, 0, 10, 1, 3'b100, 6'b101111);
      add("down_h_rel",   1, 1, 1, 10, 1, 3'b100, 6'b111111);
      add("press_setmi",  0, 1, 1, 10, 2, 3'b010, 6'b111111);
      add("rel_mode2",    1, 1, 1, 10, 2, 3'b010, 6'b111111);
      add("both_mi",      1, 0, 0, 10, 2, 3'b010, 6'b110011);
      add("both_rel",     1, 1, 1, 10, 2, 3'b010, 6'b111111);
      add("down_mi",      1, 1, 0, 10, 2, 3'b010, 6'b111011);
      add("mode_w_down",  0, 1, 0, 10, 3, 3'b001, 6'b111111);
      add("masked_hold",  1, 1, 0, 10, 3, 3'b001, 6'b111111);
      add("masked_rel",   1, 1, 1, 10, 3, 3'b001, 6'b111111);
      add("down_s",       1, 1, 0, 10, 3, 3'b001, 6'b111110);
      add("down_s_rel",   1, 1, 1, 10, 3, 3'b001, 6'b111111);
      add("up_s",         1, 0, 1, 10, 3, 3'b001, 6'b111101);
      add("up_s_rel",     1, 1, 1, 10, 3, 3'b001, 6'b111111);
      add("press_run",    0, 1, 1, 10, 0, 3'b111, 6'b111111);
      add("rel_mode3",    1, 1, 1, 10, 0, 3'b111, 6'b111111);
      add("run_up",       1, 0, 1, 10, 0, 3'b111, 6'b111111);
      add("run_down",     1, 1, 0, 10, 0, 3'b111, 6'b111111);
      add("run_rel",      1, 1, 1, 10, 0, 3'b111, 6'b111111);

      bus.pulse_1s   = 1'b0;
      bus.btn_mode_n = 1'b1;
      bus.btn_up_n   = 1'b1;
      bus.btn_down_n = 1'b1;
      rst = 1'b0;
      tick(3);
      check("rst_mode",  32'(bus.mode),  32'd0);
      check("rst_en",    32'(en_now()),  32'h7);
      check("rst_adj",   32'(adj_now()), 32'h3f);
      check("rst_blink", 32'(bus.blink), 32'd0);
      rst = 1'b1;
      tick(2);

      // Table-driven steps.
      foreach (vecs[i]) begin
         bus.btn_mode_n = vecs[i].m;
         bus.btn_up_n   = vecs[i].u;
         bus.btn_down_n = vecs[i].d;
         tick(vecs[i].cycles);
         check({vecs[i].name, "_mode"},  32'(bus.mode),  32'(vecs[i].mode));
         check({vecs[i].name, "_en"},    32'(en_now()),  32'(vecs[i].en));
         check({vecs[i].name, "_adj"},   32'(adj_now()), 32'(vecs[i].adj));
         check({vecs[i].name, "_blink"}, 32'(bus.blink), 32'(vecs[i].blink));
      end

      // Exact latency: mode changes 6 clk after the raw falling edge.
      bus.btn_mode_n = 1'b0;
      tick(5);
      check("lat_5clk", 32'(bus.mode), 32'd0);
      tick(1);
      check("lat_6clk", 32'(bus.mode), 32'd1);
      bus.btn_mode_n = 1'b1;
      tick(10);

      // Up toggling every clock in SET_H never debounces.
      ok = 1'b1;
      for (int i = 0; i < 50; i++) begin
         bus.btn_up_n = ~bus.btn_up_n;
         tick(1);
         if (bus.increase_h !== 1'b1) ok = 1'b0;
      end
      bus.btn_up_n = 1'b1;
      tick(10);
      check("toggle_no_edge", 32'(ok), 32'd1);
      check("toggle_mode",    32'(bus.mode), 32'd1);

      // Timeout from SET_MI after three idle ticks; blink toggles per tick.
      press_mode();
      check("to_start_mode", 32'(bus.mode), 32'd2);
      pulse();
      check("to_t1_mode",  32'(bus.mode),  32'd2);
      check("to_t1_blink", 32'(bus.blink), 32'd1);
      tick(2);
      pulse();
      check("to_t2_mode",  32'(bus.mode),  32'd2);
      check("to_t2_blink", 32'(bus.blink), 32'd0);
      tick(2);
      pulse();
      check("to_t3_mode",  32'(bus.mode),  32'd0);
      check("to_t3_en",    32'(en_now()),  32'h7);
      check("to_t3_blink", 32'(bus.blink), 32'd0);

      // Up press after two ticks restarts the timeout count.
      press_mode();
      press_mode();
      check("rearm_mode", 32'(bus.mode), 32'd2);
      pulse();
      tick(2);
      pulse();
      bus.btn_up_n = 1'b0;
      tick(10);
      check("rearm_up_mi", 32'(adj_now()), 32'h37);
      bus.btn_up_n = 1'b1;
      tick(10);
      pulse();
      check("rearm_t3_mode", 32'(bus.mode), 32'd2);
      tick(2);
      pulse();
      tick(2);
      pulse();
      check("rearm_expire_mode", 32'(bus.mode), 32'd0);

      // Reset in SET_S with down held and a mode press mid-debounce.
      press_mode();
      press_mode();
      press_mode();
      check("pre_rst_mode", 32'(bus.mode), 32'd3);
      bus.btn_down_n = 1'b0;
      tick(10);
      check("pre_rst_dec_s", 32'(adj_now()), 32'h3e);
      pulse();
      check("pre_rst_blink", 32'(bus.blink), 32'd1);
      bus.btn_mode_n = 1'b0;
      tick(2);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_mode",  32'(bus.mode),  32'd0);
      check("async_rst_en",    32'(en_now()),  32'h7);
      check("async_rst_adj",   32'(adj_now()), 32'h3f);
      check("async_rst_blink", 32'(bus.blink), 32'd0);
      bus.btn_mode_n = 1'b1;
      tick(2);
      rst = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (adj_now() !== 6'h3f) ok = 1'b0;
      end
      bus.btn_down_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (adj_now() !== 6'h3f) ok = 1'b0;
      end
      check("post_rst_no_adj", 32'(ok), 32'd1);
      check("post_rst_mode",   32'(bus.mode), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
